tlp_egress_router: RTL

TLP_EGRESS_ROUTER -- requirements
Module: tlp_egress_router

---
 rtl/tlp_egress_router.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/tlp_egress_router.sv
// Routes one TLP at a time (header DWs, then payload DWs) onto one of NUM_LINKS egress links.
// Define TLP_EGRESS_DROP_CNT_EN to build the saturating dropped-TLP counter; otherwise drop_cnt is 0.

module tlp_egress_router #(
  parameter int NUM_LINKS  = 4,
  parameter int HDR_DWORDS = 3,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hdr_valid,
  output logic                     hdr_ready,
  input  logic [HDR_DWORDS*32-1:0] hdr_data,
  input  logic [3:0]               hdr_dest,
  input  logic                     pld_valid,
  output logic                     pld_ready,
  input  logic [31:0]              pld_data,
  output logic [NUM_LINKS-1:0]     out_valid,
  input  logic [NUM_LINKS-1:0]     out_ready,
  output logic [NUM_LINKS*40-1:0]  out_data,
  output logic                     busy,
  output logic [15:0]              drop_cnt
);

  // state | meaning
  // IDLE  | waiting for a header; hdr_ready high
  // HDR   | presenting header DWs on the selected link
  // PLD   | forwarding payload DWs; waits for the EOP word to drain
  // DROP  | destination out of range; payload swallowed, nothing emitted

  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PLD, S_DROP} state_t;

  state_t                  r_state;
  logic [HDR_DWORDS*32-1:0] r_hdr;
  logic [3:0]              r_dest;
  logic [1:0]              r_hdr_idx;
  logic [CW-1:0]           r_rem;
  logic                    r_out_valid;
  logic [39:0]             r_out_word;
  logic                    r_hdr_ready;

  logic                    w_dest_ready;
  logic                    w_xfer;
  logic                    w_hdr_fire;
  logic                    w_pld_ready;
  logic                    w_pld_fire;
  logic [CW-1:0]           w_in_count;
  logic                    w_dest_ok;
  logic                    w_last_hdr;
  logic [1:0]              w_next_idx;
  logic [31:0]             w_next_hdr_dw;
  logic                    w_drop_done;

  function automatic logic [39:0] mk_word(input logic sop, input logic eop,
                                          input logic [3:0] dest, input logic [31:0] dw);
    return {sop, eop, 2'b00, dest, dw};
  endfunction

  always_comb begin
    w_dest_ready = 1'b0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (r_dest == 4'(i)) w_dest_ready = out_ready[i];
    end
  end

  // Length 0 with has-payload set means the maximum, 2**LEN_WIDTH DWs.
  always_comb begin
    w_in_count = '0;
    if (hdr_data[30]) begin
      if (hdr_data[LEN_WIDTH-1:0] == '0) w_in_count = {1'b1, {LEN_WIDTH{1'b0}}};
      else                               w_in_count = {1'b0, hdr_data[LEN_WIDTH-1:0]};
    end
  end

  assign w_next_idx = r_hdr_idx + 2'd1;

  always_comb begin
    w_next_hdr_dw = '0;
    for (int k = 0; k < HDR_DWORDS; k++) begin
      if (w_next_idx == 2'(k)) w_next_hdr_dw = r_hdr[32*k +: 32];
    end
  end

  always_comb begin
    w_pld_ready = 1'b0;
    case (r_state)
      S_PLD:   w_pld_ready = (r_rem != '0) && (!r_out_valid || w_dest_ready);
      S_DROP:  w_pld_ready = (r_rem != '0);
      default: w_pld_ready = 1'b0;
    endcase
  end

  assign w_xfer      = r_out_valid && w_dest_ready;
  assign w_hdr_fire  = hdr_valid && r_hdr_ready;
  assign w_pld_fire  = pld_valid && w_pld_ready;
  assign w_dest_ok   = ({1'b0, hdr_dest} < 5'(NUM_LINKS));
  assign w_last_hdr  = (r_hdr_idx == 2'(HDR_DWORDS - 1));
  assign w_drop_done = (r_state == S_DROP) &&
                       ((r_rem == '0) || (w_pld_fire && (r_rem == CW'(1))));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hdr       <= '0;
      r_dest      <= '0;
      r_hdr_idx   <= '0;
      r_rem       <= '0;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_hdr_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_hdr_ready <= 1'b1;
          if (w_hdr_fire) begin
            r_hdr       <= hdr_data;
            r_dest      <= hdr_dest;
            r_rem       <= w_in_count;
            r_hdr_idx   <= '0;
            r_hdr_ready <= 1'b0;
            if (w_dest_ok) begin
              r_state     <= S_HDR;
              r_out_valid <= 1'b1;
              r_out_word  <= mk_word(1'b1, 1'b0, hdr_dest, hdr_data[31:0]);
            end else begin
              r_state <= S_DROP;
            end
          end
        end

        S_HDR: begin
          if (w_xfer) begin
            if (w_last_hdr) begin
              r_out_valid <= 1'b0;
              r_out_word  <= '0;
              if (r_rem == '0) begin
                r_state     <= S_IDLE;
                r_hdr_ready <= 1'b1;
              end else begin
                r_state <= S_PLD;
              end
            end else begin
              r_hdr_idx  <= w_next_idx;
              r_out_word <= mk_word(1'b0,
                                    (w_next_idx == 2'(HDR_DWORDS - 1)) && (r_rem == '0),
                                    r_dest, w_next_hdr_dw);
            end
          end
        end

        // The final DW is accepted with r_rem going to 0; the state is left only once it drains.
        S_PLD: begin
          if (w_pld_fire) begin
            r_out_valid <= 1'b1;
            r_out_word  <= mk_word(1'b0, (r_rem == CW'(1)), r_dest, pld_data);
            r_rem       <= r_rem - CW'(1);
          end else if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            if (r_rem == '0) begin
              r_state     <= S_IDLE;
              r_hdr_ready <= 1'b1;
            end
          end
        end

        S_DROP: begin
          if (w_pld_fire) r_rem <= r_rem - CW'(1);
          if (w_drop_done) begin
            r_state     <= S_IDLE;
            r_hdr_ready <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LINKS; i++) begin : g_link
    assign out_valid[i]         = r_out_valid && (r_dest == 4'(i));
    assign out_data[40*i +: 40] = out_valid[i] ? r_out_word : 40'h0;
  end

  assign hdr_ready = r_hdr_ready;
  assign pld_ready = w_pld_ready;
  assign busy      = (r_state != S_IDLE);

`ifdef TLP_EGRESS_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop_done && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule
